// File: rtl/aes_pkg.sv
// Shared AES-128 constants, state encodings and byte-level round helpers.
// Byte i of a 128-bit block sits at [127-8i -: 8]; bytes 4c..4c+3 form column c.
package aes_pkg;

    localparam int AES_NR = 10;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constant for round index 1..10; other indices never reach the key step.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [6:0] byte_lsb(input int idx);
        return 7'(120 - 8 * idx);
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] s, input int idx);
        return s[byte_lsb(idx) +: 8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[byte_lsb(i) +: 8] = sbox(get_byte(s, i));
        return r;
    endfunction

    // Row r of column c takes the byte from column (c+r) mod 4.
    function automatic logic [127:0] shift_row(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[byte_lsb(4 * c + row) +: 8] = get_byte(s, 4 * ((c + row) % 4) + row);
        return r;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_column(s[127:96]), mix_column(s[95:64]),
                mix_column(s[63:32]),  mix_column(s[31:0])};
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: next round key from the current one and rcon.
// Purely combinational; four S-box lookups on the rotated last word.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] w,
    input  logic [7:0]   rc,
    output logic [127:0] w_next
);

    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] t;
    logic [31:0] w0, w1, w2, w3;

    assign rot_word = {w[23:0], w[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign sub_word[8*g +: 8] = sbox(rot_word[8*g +: 8]);
    end

    assign t  = sub_word ^ {rc, 24'h0};
    assign w0 = w[127:96] ^ t;
    assign w1 = w[95:64]  ^ w0;
    assign w2 = w[63:32]  ^ w1;
    assign w3 = w[31:0]   ^ w2;

    assign w_next = {w0, w1, w2, w3};

endmodule

// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, accept-to-out_valid latency 10 edges.
// Input accepted only in IDLE; ct held in DONE until out_ready, no bypass to a new block.
module aes_enc_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR   = AES_NR,
    parameter int KEYW = 128
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [127:0]    pt,
    input  logic [KEYW-1:0] key,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    ct,
    output logic            busy,
    output logic [3:0]      rnd
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    logic [1:0]      fsm;
    logic [127:0]    state_reg;
    logic [KEYW-1:0] rkey_reg;
    logic [127:0]    rk_next;
    logic [127:0]    sr_val;
    logic [127:0]    mid_val;
    logic [127:0]    last_val;

    aes_key_step u_key_step (
        .w      (rkey_reg),
        .rc     (rcon(rnd)),
        .w_next (rk_next)
    );

    assign sr_val   = shift_row(sub_bytes(state_reg));
    assign mid_val  = mix_columns(sr_val) ^ rk_next;
    assign last_val = sr_val ^ rk_next;

    assign in_ready = (fsm == IDLE);
    assign busy     = (fsm == ROUND);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            state_reg <= '0;
            rkey_reg  <= '0;
            rnd       <= '0;
            ct        <= '0;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= pt ^ key;
                        rkey_reg  <= key;
                        rnd       <= 4'd1;
                        fsm       <= ROUND;
                    end
                end
                ROUND: begin
                    rkey_reg <= rk_next;
                    // Final round skips MixColumns and publishes the result directly.
                    if (rnd == LAST_RND) begin
                        state_reg <= last_val;
                        ct        <= last_val;
                        out_valid <= 1'b1;
                        rnd       <= '0;
                        fsm       <= DONE;
                    end else begin
                        state_reg <= mid_val;
                        rnd       <= rnd + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        fsm       <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// Bench for aes_enc_round_ctrl: FIPS-197 vectors, backpressure, back-to-back, reset abort
// and random blocks checked against an independent byte-array AES model.
module tb_aes_enc_round_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] pt = '0;
    logic [127:0] key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] ct;
    logic         busy;
    logic [3:0]   rnd;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sb [256];

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_enc_round_ctrl #(.NR(10), .KEYW(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pt        (pt),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ct        (ct),
        .busy      (busy),
        .rnd       (rnd)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- reference model (GF(2^8) arithmetic, byte arrays) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int u = 1; u < 256; u++)
                if (gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[v] = s;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t2 [16];
        logic [7:0]   rc = 8'h01;
        logic [31:0]  tw;
        logic [127:0] res = '0;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {tw[23:0], tw[31:24]};
                tw = {sb[tw[31:24]], sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t2[4*c + row] = s[4*((c + row) % 4) + row];
            for (int i = 0; i < 16; i++) s[i] = t2[i];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int row = 0; row < 4; row++)
                        t2[4*c + row] = gmul(s[4*c + row], 8'h02)
                                      ^ gmul(s[4*c + (row+1)%4], 8'h03)
                                      ^ s[4*c + (row+2)%4] ^ s[4*c + (row+3)%4];
                end
                for (int i = 0; i < 16; i++) s[i] = t2[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Offers a block until accepted; returns with the accept edge just behind us.
    task automatic accept_block(input logic [127:0] p, input logic [127:0] k, input string tag);
        bit rdy_b;
        bit acc = 1'b0;
        pt = p; key = k; in_valid = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            rdy_b = in_ready;
            tick();
            acc = rdy_b;
        end
        check({tag, "_accept"}, 128'(acc), 128'(1));
    endtask

    task automatic run_block(input logic [127:0] p, input logic [127:0] k, input logic [127:0] exp,
                             input bit scramble, input bit early_rdy, input int hold, input string tag);
        int lat = 0;
        logic [127:0] ct_seen;
        out_ready = 1'b0;
        accept_block(p, k, tag);
        in_valid = 1'b0;
        if (early_rdy) out_ready = 1'b1;
        while (!out_valid && lat < 30) begin
            if (lat == 4) begin
                check({tag, "_rnd_mid"}, 128'(rnd), 128'(5));
                check({tag, "_busy_mid"}, 128'(busy), 128'(1));
            end
            if (scramble) begin
                pt = rand128(); key = rand128(); in_valid = 1'($urandom_range(0, 1));
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 128'(lat), 128'(10));
        check({tag, "_ct"}, ct, exp);
        ct_seen = ct;
        if (!early_rdy) begin
            repeat (hold) tick();
            check({tag, "_held_valid"}, 128'(out_valid), 128'(1));
            check({tag, "_held_ct"}, ct, ct_seen);
            out_ready = 1'b1;
        end
        tick();
        check({tag, "_post_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_post_ready"}, 128'(in_ready), 128'(1));
        out_ready = 1'b0;
    endtask

    initial begin
        int out_cyc [$];
        logic [127:0] out_ct [$];
        int acc_cnt;
        bit will_acc;
        bit found;

        build_sbox();

        // Reset state
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_rnd", 128'(rnd), 128'(0));
        check("rst_ct", ct, 128'(0));

        // FIPS-197 vectors, including input change after accept
        run_block(PT_B, KEY_B, CT_B, 1'b0, 1'b0, 0, "fips_b");
        run_block(PT_C, KEY_C, CT_C, 1'b1, 1'b1, 0, "fips_c_scramble");

        // Backpressure: ct held, in_ready low, new input pulses ignored
        accept_block(PT_B, KEY_B, "bp");
        in_valid = 1'b0;
        for (int i = 0; i < 30 && !out_valid; i++) tick();
        check("bp_valid", 128'(out_valid), 128'(1));
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'(i % 2);
            pt = rand128(); key = rand128();
            tick();
            check("bp_ct_stable", ct, CT_B);
            check("bp_in_ready", 128'(in_ready), 128'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 128'(out_valid), 128'(0));
        check("bp_release_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b0;

        // Back-to-back: two App. B blocks, outputs exactly 12 cycles apart
        pt = PT_B; key = KEY_B; in_valid = 1'b1; out_ready = 1'b1;
        acc_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            will_acc = in_valid && in_ready;
            tick();
            if (will_acc) begin
                acc_cnt++;
                if (acc_cnt == 2) in_valid = 1'b0;
            end
            if (out_valid) begin
                out_cyc.push_back(c);
                out_ct.push_back(ct);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_count", 128'(out_cyc.size()), 128'(2));
        if (out_cyc.size() == 2) begin
            check("b2b_ct0", out_ct[0], CT_B);
            check("b2b_ct1", out_ct[1], CT_B);
            check("b2b_gap", 128'(out_cyc[1] - out_cyc[0]), 128'(12));
        end

        // Reset during round 5 discards the block
        accept_block(PT_B, KEY_B, "rst_mid");
        in_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (rnd == 4'd5) found = 1'b1;
            else tick();
        end
        check("rst_mid_reach_rnd5", 128'(found), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_in_ready", 128'(in_ready), 128'(1));
        check("rst_mid_out_valid", 128'(out_valid), 128'(0));
        check("rst_mid_rnd", 128'(rnd), 128'(0));
        check("rst_mid_busy", 128'(busy), 128'(0));
        run_block(PT_C, KEY_C, CT_C, 1'b0, 1'b1, 0, "after_rst");

        // Random blocks against the model
        for (int n = 0; n < 12; n++) begin
            logic [127:0] rp, rk;
            rp = rand128(); rk = rand128();
            run_block(rp, rk, aes_ref(rp, rk), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
